uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
- UART transmitter; the transmit-side counterpart of the UART receive FSM.
- Serialises one byte per frame: 1 start bit (0), 8 data bits LSB-first, [optional parity], 1 stop bit (1).
- Sits between the ALU result/command path and the board TX pin. It shares the CLKS_PER_BIT baud convention with the receiver, so both ends run at the same rate from the same clock.
- Single-byte holding register with a valid/ready handshake; no FIFO.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- tx_valid  input  1  producer has a byte on tx_data.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_ready  output  1  block can accept a byte this cycle.
- uart_tx  output  1  serial line; idle high.
- tx_busy  output  1  a frame is in progress (state != IDLE).
- tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - clk_count=0, bit_index=0, shift register=0.
- Outputs: all outputs are registered; uart_tx never glitches.
- Internal counters: clk_count is 16 bits, bit_index is 3 bits.
- Handshake:
  - Accept occurs when tx_valid && tx_ready on a rising edge; tx_data is latched into the shift register.
  - tx_ready=1 only in IDLE; it drops in the cycle after accept.
  - tx_data and tx_valid are don't-care while busy.
- IDLE:
  - uart_tx=1.
  - On accept -> START; clk_count=0.
- START:
  - uart_tx=0.
  - When clk_count==CLKS_PER_BIT-1 -> DATA; clk_count=0, bit_index=0.
  - Otherwise clk_count++.
- DATA:
  - uart_tx=shift[0].
  - At clk_count==CLKS_PER_BIT-1: shift right, clk_count=0.
    - If bit_index==7 -> STOP (or PARITY when the option is enabled).
    - Otherwise bit_index++.
  - bit_index never wraps past 7.
- STOP:
  - uart_tx=1.
  - At clk_count==CLKS_PER_BIT-1 -> IDLE; clk_count=0; tx_done=1 for exactly that one cycle.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the first IDLE cycle (11*CLKS_PER_BIT with parity).
- Latency: the start bit appears on uart_tx the cycle after accept.
- Back-to-back:
  - tx_ready is high in the first IDLE cycle after tx_done.
  - With tx_valid held high, the next start bit begins one cycle later, giving a minimum 1-cycle idle-high gap between frames.
- Mid-frame reset: rst low at any time forces uart_tx=1 and state=IDLE immediately. The partial frame is abandoned and tx_done is not pulsed.
- Illegal state encoding: falls back to IDLE with uart_tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - uart_tx = even parity (XOR of the 8 data bits), computed at accept.
  - Frame = 11 bit times.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - Frame = 10 bit times; no parity logic is synthesised.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset: hold rst=0 for 3 cycles -> uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0. Release -> no change while tx_valid=0.
- Single byte: tx_data=8'hA5, tx_valid pulse.
  - uart_tx bit sequence 0,1,0,1,0,0,1,0,1,1; each bit held exactly 4 cycles.
  - tx_done pulses once at cycle 40 after accept; tx_ready returns to 1.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF.
  - Two frames separated by exactly 1 idle-high cycle.
  - Second frame data bits all 1; tx_data changes mid-frame are ignored.
- Mid-frame reset: assert rst=0 during DATA bit 3 of 8'h0F -> uart_tx=1 asynchronously, tx_busy=0, no tx_done. A new byte 8'h3C is then sent correctly.
- Baud parameter: CLKS_PER_BIT=434, byte 8'h55 -> each bit 434 cycles, total frame 4340 cycles, LSB first.
- UART_TX_PARITY_EN defined:
  - 8'h07 -> parity bit 1.
  - 8'h03 -> parity bit 0.
  - Frame = 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between the data and stop bits.
module uart_tx_fsm #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] LastCount = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t      state_q;
  logic [15:0] clkCount_q;
  logic [2:0]  bitIndex_q;
  logic [7:0]  shift_q;
  logic        line_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  logic countDone_d;
  assign countDone_d = (clkCount_q == LastCount);

  assign tx_ready = ready_q;
  assign uart_tx  = line_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // Every output is a flop so the serial line only changes on clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      clkCount_q <= '0;
      bitIndex_q <= '0;
      shift_q    <= '0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q     <= 1'b1;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          clkCount_q <= '0;
          bitIndex_q <= '0;
          if (tx_valid && ready_q) begin
            state_q <= START;
            shift_q <= tx_data;
            line_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_data;
`endif
          end
        end
        START: begin
          if (countDone_d) begin
            state_q    <= DATA;
            clkCount_q <= '0;
            bitIndex_q <= '0;
            line_q     <= shift_q[0];
          end else begin
            clkCount_q <= clkCount_q + 16'd1;
          end
        end
        DATA: begin
          if (countDone_d) begin
            clkCount_q <= '0;
            shift_q    <= {1'b0, shift_q[7:1]};
            if (bitIndex_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              line_q  <= parity_q;
`else
              state_q <= STOP;
              line_q  <= 1'b1;
`endif
            end else begin
              bitIndex_q <= bitIndex_q + 3'd1;
              line_q     <= shift_q[1];
            end
          end else begin
            clkCount_q <= clkCount_q + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (countDone_d) begin
            state_q    <= STOP;
            clkCount_q <= '0;
            line_q     <= 1'b1;
          end else begin
            clkCount_q <= clkCount_q + 16'd1;
          end
        end
`endif
        STOP: begin
          line_q <= 1'b1;
          if (countDone_d) begin
            state_q    <= IDLE;
            clkCount_q <= '0;
            done_q     <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clkCount_q <= clkCount_q + 16'd1;
          end
        end
        // Unreachable encodings recover to a quiet idle line.
        default: begin
          state_q    <= IDLE;
          clkCount_q <= '0;
          bitIndex_q <= '0;
          line_q     <= 1'b1;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: a 4-clock-per-bit instance for most checks and a
// 434-clock-per-bit instance for the baud check. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fsm;

`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       validA = 1'b0, validB = 1'b0;
  logic [7:0] dataA = 8'h00, dataB = 8'h00;
  logic       readyA, txA, busyA, doneA;
  logic       readyB, txB, busyB, doneB;
  logic       sel = 1'b0;
  logic       curTx, curReady, curBusy, curDone;
  int         testsRun = 0;
  int         testsFailed = 0;

  always #5 clk = ~clk;

  uart_tx_fsm #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .tx_valid(validA), .tx_data(dataA),
    .tx_ready(readyA), .uart_tx(txA), .tx_busy(busyA), .tx_done(doneA)
  );

  uart_tx_fsm #(.CLKS_PER_BIT(434)) dut434 (
    .clk(clk), .rst(rst), .tx_valid(validB), .tx_data(dataB),
    .tx_ready(readyB), .uart_tx(txB), .tx_busy(busyB), .tx_done(doneB)
  );

  assign curTx    = sel ? txB    : txA;
  assign curReady = sel ? readyB : readyA;
  assign curBusy  = sel ? busyB  : busyA;
  assign curDone  = sel ? doneB  : doneA;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    if (sel) begin
      validB = v;
      dataB  = d;
    end else begin
      validA = v;
      dataA  = d;
    end
  endtask

  function automatic logic expBit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Called at the falling edge just after the accept edge; ends on the first idle cycle.
  task automatic checkFrame(input string tag, input logic [7:0] data, input int changeAt,
                            input logic newValid, input logic [7:0] newData);
    int cpb;
    int bitErrs;
    int doneErrs;
    cpb = sel ? 434 : 4;
    doneErrs = 0;
    checkOutput({tag, "_ready_low"}, {31'b0, curReady}, 32'd0);
    checkOutput({tag, "_busy_high"}, {31'b0, curBusy}, 32'd1);
    for (int k = 0; k < NBits; k++) begin
      bitErrs = 0;
      for (int c = 0; c < cpb; c++) begin
        if (k * cpb + c == changeAt) applyStimulus(newValid, newData);
        if (curTx !== expBit(data, k)) bitErrs++;
        if (curDone !== 1'b0) doneErrs++;
        if (!(k == NBits - 1 && c == cpb - 1)) @(negedge clk);
      end
      checkOutput($sformatf("%s_bit%0d", tag, k), bitErrs, 32'd0);
    end
    checkOutput({tag, "_done_quiet"}, doneErrs, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, curDone}, 32'd1);
    checkOutput({tag, "_ready_back"}, {31'b0, curReady}, 32'd1);
    checkOutput({tag, "_busy_clear"}, {31'b0, curBusy}, 32'd0);
    checkOutput({tag, "_line_idle"}, {31'b0, curTx}, 32'd1);
  endtask

  task automatic midFrameReset(input string tag, input int atIndex, input logic preLine);
    int doneSeen;
    doneSeen = 0;
    applyStimulus(1'b1, 8'h0F);
    @(negedge clk);
    applyStimulus(1'b0, 8'h0F);
    repeat (atIndex) @(negedge clk);
    checkOutput({tag, "_pre_line"}, {31'b0, curTx}, {31'b0, preLine});
    checkOutput({tag, "_pre_busy"}, {31'b0, curBusy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput({tag, "_async_line"}, {31'b0, curTx}, 32'd1);
    checkOutput({tag, "_async_busy"}, {31'b0, curBusy}, 32'd0);
    checkOutput({tag, "_async_ready"}, {31'b0, curReady}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (curDone !== 1'b0) doneSeen++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (curDone !== 1'b0) doneSeen++;
    end
    checkOutput({tag, "_no_done"}, doneSeen, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_line", {31'b0, txA}, 32'd1);
    checkOutput("rst_ready", {31'b0, readyA}, 32'd1);
    checkOutput("rst_busy", {31'b0, busyA}, 32'd0);
    checkOutput("rst_done", {31'b0, doneA}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_line", {31'b0, txA}, 32'd1);
    checkOutput("post_rst_busy", {31'b0, busyA}, 32'd0);
    checkOutput("post_rst_ready", {31'b0, readyA}, 32'd1);

    applyStimulus(1'b1, 8'hA5);
    @(negedge clk);
    checkFrame("a5", 8'hA5, 0, 1'b0, 8'hA5);
    @(negedge clk);
    checkOutput("a5_done_once", {31'b0, doneA}, 32'd0);

    applyStimulus(1'b1, 8'h00);
    @(negedge clk);
    checkFrame("b2b0", 8'h00, 0, 1'b1, 8'hFF);
    @(negedge clk);
    checkFrame("b2b1", 8'hFF, 20, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("b2b_stays_idle", {31'b0, busyA}, 32'd0);

    midFrameReset("mrst3", 17, 1'b1);
    midFrameReset("mrst4", 21, 1'b0);
    applyStimulus(1'b1, 8'h3C);
    @(negedge clk);
    checkFrame("after_rst_3c", 8'h3C, 0, 1'b0, 8'h3C);

    applyStimulus(1'b1, 8'h07);
    @(negedge clk);
    checkFrame("par07", 8'h07, 0, 1'b0, 8'h07);
    applyStimulus(1'b1, 8'h03);
    @(negedge clk);
    checkFrame("par03", 8'h03, 0, 1'b0, 8'h03);

    sel = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'h55);
    @(negedge clk);
    checkFrame("baud434", 8'h55, 0, 1'b0, 8'h55);
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
